// File: rtl/pcr_trap_unit_if.sv
// PCR access bus and host mailbox shared between the execute stage, the host
// and the privileged control register unit.
interface pcr_trap_unit_if #(
   parameter int XLEN = 32
);
   logic            enable;
   logic [1:0]      cmd;
   logic [4:0]      pcr_addr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata;
   logic            tohost_valid;
   logic [XLEN-1:0] tohost_data;
   logic            tohost_ready;
   logic            fromhost_we;
   logic [XLEN-1:0] fromhost_wdata;

   modport master (
      output enable, cmd, pcr_addr, wdata, tohost_ready, fromhost_we, fromhost_wdata,
      input  rdata, tohost_valid, tohost_data
   );

   modport slave (
      input  enable, cmd, pcr_addr, wdata, tohost_ready, fromhost_we, fromhost_wdata,
      output rdata, tohost_valid, tohost_data
   );
endinterface

// File: rtl/pcr_trap_unit.sv
// Privileged control register file for the Invicta core: MTPCR/SETPCR/CLEARPCR
// access, count/compare timer, interrupt pending state, trap entry, eret and
// the tohost/fromhost mailbox.
module pcr_trap_unit #(
   parameter int XLEN       = 32,
   parameter int NUM_IRQ    = 8,
   parameter int EVEC_ALIGN = 2
) (
   input  logic               clk,
   input  logic               reset,
   pcr_trap_unit_if.slave     bus,
   input  logic               stall,
   input  logic [XLEN-1:0]    pc,
   input  logic               exception,
   input  logic [4:0]         exc_cause,
   input  logic [XLEN-1:0]    exc_badvaddr,
   input  logic               eret,
   input  logic [NUM_IRQ-1:0] ext_irq,
   output logic               trap_valid,
   output logic               eret_valid,
   output logic [XLEN-1:0]    evec,
   output logic [XLEN-1:0]    epc_out,
   output logic [XLEN-1:0]    ptbr,
   output logic               vm_enable,
   output logic               flush_tlb
);

   localparam logic [4:0] ADDR_STATUS   = 5'd0;
   localparam logic [4:0] ADDR_EPC      = 5'd1;
   localparam logic [4:0] ADDR_BADVADDR = 5'd2;
   localparam logic [4:0] ADDR_EVEC     = 5'd3;
   localparam logic [4:0] ADDR_COUNT    = 5'd4;
   localparam logic [4:0] ADDR_COMPARE  = 5'd5;
   localparam logic [4:0] ADDR_CAUSE    = 5'd6;
   localparam logic [4:0] ADDR_PTBR     = 5'd7;
   localparam logic [4:0] ADDR_K0       = 5'd9;
   localparam logic [4:0] ADDR_K1       = 5'd10;
   localparam logic [4:0] ADDR_TOHOST   = 5'd30;
   localparam logic [4:0] ADDR_FROMHOST = 5'd31;

   localparam logic [1:0] CMD_READ  = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_SET   = 2'd2;

   localparam logic [XLEN-1:0] EVEC_MASK = ~((XLEN'(1) << EVEC_ALIGN) - XLEN'(1));
   localparam logic [XLEN-1:0] IRQ_FLAG  = XLEN'(1) << (XLEN - 1);

   logic               et_q, s_q, ps_q, vm_q;
   logic [NUM_IRQ-1:0] im_q, ext_q, ip, pending;
   logic               timer_pend_q, host_pend;
   logic [XLEN-1:0]    epc_q, badvaddr_q, evec_q, count_q, compare_q, cause_q;
   logic [XLEN-1:0]    ptbr_q, k0_q, k1_q, tohost_q, fromhost_q;
   logic               tohost_valid_q, trap_valid_q, eret_valid_q;
   logic [XLEN-1:0]    status_rd, old_val, new_val, trap_cause;
   logic               irq_req, take_trap, do_eret, commit, addr_code;
   logic               wr_status, wr_epc, wr_evec, wr_count, wr_compare;
   logic               wr_ptbr, wr_k0, wr_k1, wr_tohost, wr_fromhost;
   logic [2:0]         irq_idx;

   assign host_pend = (fromhost_q != '0);

   generate
      if (NUM_IRQ == 8) begin : g_full_irq
         logic unused_ext;
         assign ip         = {timer_pend_q, host_pend, ext_q[5:0]};
         assign unused_ext = &{1'b0, ext_q[7:6]};
      end else begin : g_ext_irq
         logic unused_internal;
         assign ip              = ext_q;
         assign unused_internal = &{1'b0, timer_pend_q, host_pend};
      end
   endgenerate

   assign pending   = im_q & ip;
   assign irq_req   = et_q & (|pending);
   assign take_trap = !stall & (exception | irq_req);
   assign do_eret   = !stall & eret & !take_trap;
   assign commit    = bus.enable & !stall & (bus.cmd != CMD_READ) & !take_trap;
   assign addr_code = (exc_cause == 5'd0) | (exc_cause == 5'd1) |
                      (exc_cause == 5'd10) | (exc_cause == 5'd11);

   assign wr_status   = commit & (bus.pcr_addr == ADDR_STATUS);
   assign wr_epc      = commit & (bus.pcr_addr == ADDR_EPC);
   assign wr_evec     = commit & (bus.pcr_addr == ADDR_EVEC);
   assign wr_count    = commit & (bus.pcr_addr == ADDR_COUNT);
   assign wr_compare  = commit & (bus.pcr_addr == ADDR_COMPARE);
   assign wr_ptbr     = commit & (bus.pcr_addr == ADDR_PTBR);
   assign wr_k0       = commit & (bus.pcr_addr == ADDR_K0);
   assign wr_k1       = commit & (bus.pcr_addr == ADDR_K1);
   assign wr_tohost   = commit & (bus.pcr_addr == ADDR_TOHOST);
   assign wr_fromhost = commit & (bus.pcr_addr == ADDR_FROMHOST);

   // Pick the highest-numbered enabled pending interrupt line
   always_comb begin
      irq_idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (pending[i]) begin
            irq_idx = 3'(i);
         end
      end
   end

   assign trap_cause = exception ? XLEN'(exc_cause) : (IRQ_FLAG | XLEN'(irq_idx));

   // Assemble the architectural view of status; unlisted bits read as zero
   always_comb begin
      status_rd                 = '0;
      status_rd[0]              = et_q;
      status_rd[2]              = s_q;
      status_rd[3]              = ps_q;
      status_rd[8]              = vm_q;
      status_rd[16 +: NUM_IRQ]  = im_q;
      status_rd[24 +: NUM_IRQ]  = ip;
   end

   // Current value of the addressed register, before any write this cycle
   always_comb begin
      old_val = '0;
      case (bus.pcr_addr)
         ADDR_STATUS:   old_val = status_rd;
         ADDR_EPC:      old_val = epc_q;
         ADDR_BADVADDR: old_val = badvaddr_q;
         ADDR_EVEC:     old_val = evec_q;
         ADDR_COUNT:    old_val = count_q;
         ADDR_COMPARE:  old_val = compare_q;
         ADDR_CAUSE:    old_val = cause_q;
         ADDR_PTBR:     old_val = ptbr_q;
         ADDR_K0:       old_val = k0_q;
         ADDR_K1:       old_val = k1_q;
         ADDR_TOHOST:   old_val = tohost_q;
         ADDR_FROMHOST: old_val = fromhost_q;
         default:       old_val = '0;
      endcase
   end

   // Combine the old value with the operand according to the access kind
   always_comb begin
      new_val = old_val & ~bus.wdata;
      if (bus.cmd == CMD_WRITE) begin
         new_val = bus.wdata;
      end else if (bus.cmd == CMD_SET) begin
         new_val = old_val | bus.wdata;
      end
   end

   assign bus.rdata        = bus.enable ? old_val : '0;
   assign bus.tohost_valid = tohost_valid_q;
   assign bus.tohost_data  = tohost_q;
   assign trap_valid       = trap_valid_q;
   assign eret_valid       = eret_valid_q;
   assign evec             = evec_q;
   assign epc_out          = epc_q;
   assign ptbr             = ptbr_q;
   assign vm_enable        = vm_q;
   assign flush_tlb        = wr_ptbr;

   // Status fields, trap entry, eret return and the fetch-redirect pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         et_q         <= 1'b0;
         s_q          <= 1'b1;
         ps_q         <= 1'b0;
         vm_q         <= 1'b0;
         im_q         <= '0;
         epc_q        <= '0;
         cause_q      <= '0;
         badvaddr_q   <= '0;
         trap_valid_q <= 1'b0;
         eret_valid_q <= 1'b0;
      end else begin
         trap_valid_q <= take_trap;
         eret_valid_q <= do_eret;
         if (take_trap) begin
            epc_q   <= pc;
            cause_q <= trap_cause;
            if (exception && addr_code) begin
               badvaddr_q <= exc_badvaddr;
            end
            ps_q <= s_q;
            s_q  <= 1'b1;
            et_q <= 1'b0;
         end else begin
            if (do_eret) begin
               s_q  <= ps_q;
               et_q <= 1'b1;
            end
            if (wr_status) begin
               et_q <= new_val[0];
               s_q  <= new_val[2];
               ps_q <= new_val[3];
               vm_q <= new_val[8];
               im_q <= new_val[16 +: NUM_IRQ];
            end
            if (wr_epc) begin
               epc_q <= new_val;
            end
         end
      end
   end

   // Free-running counter, sticky compare match and sampled interrupt lines
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q      <= '0;
         timer_pend_q <= 1'b0;
         ext_q        <= '0;
      end else begin
         ext_q   <= ext_irq;
         count_q <= wr_count ? new_val : count_q + XLEN'(1);
         if (wr_compare) begin
            timer_pend_q <= 1'b0;
         end else if (count_q == compare_q) begin
            timer_pend_q <= 1'b1;
         end
      end
   end

   // Plain software-owned registers
   always_ff @(posedge clk) begin
      if (reset) begin
         evec_q    <= '0;
         compare_q <= '0;
         ptbr_q    <= '0;
         k0_q      <= '0;
         k1_q      <= '0;
      end else begin
         if (wr_evec)    evec_q    <= new_val & EVEC_MASK;
         if (wr_compare) compare_q <= new_val;
         if (wr_ptbr)    ptbr_q    <= new_val;
         if (wr_k0)      k0_q      <= new_val;
         if (wr_k1)      k1_q      <= new_val;
      end
   end

   // Host mailbox: tohost handshake and host-written fromhost
   always_ff @(posedge clk) begin
      if (reset) begin
         tohost_q       <= '0;
         tohost_valid_q <= 1'b0;
         fromhost_q     <= '0;
      end else begin
         if (wr_tohost) begin
            tohost_q       <= new_val;
            tohost_valid_q <= 1'b1;
         end else if (bus.tohost_ready && tohost_valid_q) begin
            tohost_valid_q <= 1'b0;
         end
         if (bus.fromhost_we) begin
            fromhost_q <= bus.fromhost_wdata;
         end else if (wr_fromhost) begin
            fromhost_q <= new_val;
         end
      end
   end

endmodule
